// File: rtl/branch_lut_pkg.sv
// Shared types and power-on default contents for the branch target lookup table.
package branch_lut_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } lut_state_e;

   typedef enum logic {
      MODE_OFS = 1'b0,
      MODE_ABS = 1'b1
   } lut_mode_e;

   // Entries not listed hold a unit forward offset.
   function automatic int lut_default(input int idx);
      case (idx)
         0:       return -370;
         1:       return -447;
         7:       return -343;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/branch_lut_init_seq.sv
// Post-reset sequencer: walks every table entry once to load defaults, then parks in READY.
//
// state | meaning
// INIT  | loading default entry cnt this cycle; busy, user traffic blocked
// READY | normal operation until the next reset
module branch_lut_init_seq
   import branch_lut_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             init_we,
   output logic [IDX_W-1:0] init_idx,
   output logic             busy
);

   lut_state_e       state_q;
   lut_state_e       state_d;
   logic [IDX_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == INIT) && (cnt_q == '1)) begin
         state_d = READY;
      end
   end

   always_comb begin
      init_we  = (state_q == INIT);
      busy     = (state_q == INIT);
      init_idx = cnt_q;
   end

endmodule

// File: rtl/branch_target_lut.sv
// Programmable branch offset table with registered read, write forwarding and PC-relative mode.
// Optional read/forward performance counters are built when BRANCH_LUT_PERF_CNT_EN is defined.
module branch_target_lut
   import branch_lut_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int OUT_W = 11,
   parameter int PC_W  = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] index,
   input  logic             rd_en,
   input  logic             mode,
   input  logic [PC_W-1:0]  pc,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OUT_W-1:0] wr_data,
   output logic             busy,
   output logic [OUT_W-1:0] out,
   output logic             rd_valid,
   output logic             wr_err,
   output logic [15:0]      perf_reads,
   output logic [15:0]      perf_fwd
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [OUT_W-1:0] mem [DEPTH];

   logic             init_we;
   logic [IDX_W-1:0] init_idx;
   logic             rd_fire;
   logic             wr_fire;
   logic             fwd;
   logic [OUT_W-1:0] rd_entry;
   logic [PC_W-1:0]  ofs_ext;
   logic [PC_W-1:0]  abs_sum;
   logic [OUT_W-1:0] rd_result;

   branch_lut_init_seq #(
      .IDX_W (IDX_W)
   ) u_init_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_we  (init_we),
      .init_idx (init_idx),
      .busy     (busy)
   );

   assign rd_fire = rd_en & ~busy;
   assign wr_fire = wr_en & ~busy;
   assign fwd     = wr_fire & (wr_idx == index);

   always_comb begin
      rd_entry  = fwd ? wr_data : mem[index];
      ofs_ext   = PC_W'($signed(rd_entry));
      abs_sum   = pc + ofs_ext;
      rd_result = (mode == MODE_ABS) ? OUT_W'(abs_sum) : rd_entry;
   end

   // Table storage has no reset; contents are only meaningful once init has swept it.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_idx] <= OUT_W'(lut_default(int'(init_idx)));
      end else if (wr_fire) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out      <= '0;
         rd_valid <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         wr_err   <= wr_en & busy;
         if (rd_fire) begin
            out <= rd_result;
         end
      end
   end

`ifdef BRANCH_LUT_PERF_CNT_EN
   logic [15:0] perf_reads_q;
   logic [15:0] perf_fwd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_reads_q <= '0;
         perf_fwd_q   <= '0;
      end else begin
         if (rd_fire && (perf_reads_q != 16'hFFFF)) begin
            perf_reads_q <= perf_reads_q + 16'd1;
         end
         if (rd_fire && fwd && (perf_fwd_q != 16'hFFFF)) begin
            perf_fwd_q <= perf_fwd_q + 16'd1;
         end
      end
   end

   assign perf_reads = perf_reads_q;
   assign perf_fwd   = perf_fwd_q;
`else
   assign perf_reads = '0;
   assign perf_fwd   = '0;
`endif

endmodule

// File: tb/tb_branch_target_lut.sv
// Scoreboard bench for branch_target_lut: random reads/writes against an array model of the table.
module tb_branch_target_lut;

   localparam int IDX_W = 4;
   localparam int OUT_W = 11;
   localparam int PC_W  = 11;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [IDX_W-1:0] index = '0;
   logic             rd_en = 1'b0;
   logic             mode = 1'b0;
   logic [PC_W-1:0]  pc = '0;
   logic             wr_en = 1'b0;
   logic [IDX_W-1:0] wr_idx = '0;
   logic [OUT_W-1:0] wr_data = '0;
   logic             busy;
   logic [OUT_W-1:0] out;
   logic             rd_valid;
   logic             wr_err;
   logic [15:0]      perf_reads;
   logic [15:0]      perf_fwd;

   branch_target_lut #(
      .IDX_W (IDX_W),
      .OUT_W (OUT_W),
      .PC_W  (PC_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .index      (index),
      .rd_en      (rd_en),
      .mode       (mode),
      .pc         (pc),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .busy       (busy),
      .out        (out),
      .rd_valid   (rd_valid),
      .wr_err     (wr_err),
      .perf_reads (perf_reads),
      .perf_fwd   (perf_fwd)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          exp_q[$];
   int          model[DEPTH];
   int          n_reads = 0;
   int          n_fwd = 0;
   logic [31:0] last_out = '0;
   int          mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = 1;
      model[0] = -370;
      model[1] = -447;
      model[7] = -343;
      n_reads  = 0;
      n_fwd    = 0;
   endtask

   function automatic int wrap11(input int v);
      return ((v % 2048) + 2048) % 2048;
   endfunction

   // Scoreboard monitor: every rd_valid consumes the oldest expected result.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_out = '0;
      end else if (rd_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rd_valid", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("read_out", {21'd0, out}, mon_e);
         end
         last_out = {21'd0, out};
      end else begin
         check("out_hold", {21'd0, out}, last_out);
      end
   end

   // One cycle of stimulus, issued at a falling edge; expectation derived from the model.
   task automatic drive(input bit rd, input int idx, input bit md, input int pcv,
                        input bit wr, input int widx, input int wdata);
      int e;
      rd_en   = rd;
      index   = IDX_W'(idx);
      mode    = md;
      pc      = PC_W'(pcv);
      wr_en   = wr;
      wr_idx  = IDX_W'(widx);
      wr_data = OUT_W'(wdata);
      if (rd) begin
         e = (wr && widx == idx) ? wdata : model[idx];
         if (wr && widx == idx) n_fwd++;
         if (md) e = pcv + e;
         exp_q.push_back(wrap11(e));
         n_reads++;
      end
      if (wr) model[widx] = wdata;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Reset, then release and watch the init sweep with reads requested throughout.
   // stop_at > 0 leaves the sequencer mid-init after that many cycles.
   task automatic reset_init(input bit traffic, input int stop_at);
      int n = 0;
      int werr = 0;
      int rv = 0;
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      rd_en = 0;
      wr_en = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 1);
      check("reset_out", {21'd0, out}, 0);
      check("reset_rd_valid", {31'd0, rd_valid}, 0);
      check("reset_wr_err", {31'd0, wr_err}, 0);
      model_reset();
      rd_en = 1;
      index = IDX_W'($urandom_range(0, DEPTH - 1));
      rst_n = 1;
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         if (stop_at > 0 && k == stop_at) break;
         n++;
         if (wr_err) werr++;
         if (rd_valid) rv++;
         wr_en   = traffic && (k == 3);
         wr_idx  = 4'd5;
         wr_data = 11'd42;
         @(negedge clk);
      end
      rd_en = 0;
      wr_en = 0;
      check("init_rd_valid_count", rv, 0);
      if (stop_at > 0) begin
         check("busy_before_abort", n, stop_at);
      end else begin
         check("init_busy_cycles", n, 16);
         check("init_wr_err_count", werr, traffic ? 1 : 0);
      end
   endtask

   task automatic check_perf();
      int er;
      int ef;
`ifdef BRANCH_LUT_PERF_CNT_EN
      er = n_reads;
      ef = n_fwd;
`else
      er = 0;
      ef = 0;
`endif
      check("perf_reads", {16'd0, perf_reads}, er);
      check("perf_fwd", {16'd0, perf_fwd}, ef);
   endtask

   initial begin
      int ri;
      int wi;
      @(negedge clk);
      reset_init(1, 0);

      // Default contents and the write dropped during init.
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 7, 0, 0, 0, 0, 0);
      drive(1, 3, 0, 0, 0, 0, 0);
      drive(1, 5, 0, 0, 0, 0, 0);
      idle(1);

      // Forwarding, then persistence of the forwarded write.
      drive(1, 2, 0, 0, 1, 2, 100);
      drive(1, 2, 0, 0, 0, 0, 0);
      // Absolute mode, including wrap below zero.
      drive(1, 0, 1, 500, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 3, -1);
      drive(1, 3, 1, 0, 0, 0, 0);
      drive(1, 4, 0, 0, 1, 9, 77);
      drive(1, 15, 1, 2047, 0, 0, 0);
      idle(2);

      for (int i = 0; i < 300; i++) begin
         ri = $urandom_range(0, DEPTH - 1);
         wi = ($urandom_range(0, 3) == 0) ? ri : $urandom_range(0, DEPTH - 1);
         drive($urandom_range(0, 3) != 0, ri, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2047), $urandom_range(0, 2) == 0, wi,
               $urandom_range(0, 2047) - 1024);
      end
      idle(3);
      check_perf();

      // Reset pulsed in the middle of init, then a full clean init.
      reset_init(0, 8);
      reset_init(0, 0);

      for (int i = 0; i < 20; i++) begin
         if (i == 4 || i == 9 || i == 14) drive(1, i % DEPTH, 0, 0, 1, i % DEPTH, 200 + i);
         else drive(1, i % DEPTH, 0, 0, 0, 0, 0);
      end
      idle(3);
      check("perf_model_reads", n_reads, 20);
      check("perf_model_fwd", n_fwd, 3);
      check_perf();

      check("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
